// File: rtl/sync_debounce_bank.sv
// Multi-channel input conditioner: per-channel flop synchroniser, glitch-rejecting debounce filter, level plus rise/fall pulses.
// Optional request latch enabled by SYNC_DEBOUNCE_REQ_LATCH_EN (adds req_clr input and req_pending output).
module sync_debounce_bank #(
  parameter int WIDTH           = 4,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
  ,
  input  logic [WIDTH-1:0] req_clr,
  output logic [WIDTH-1:0] req_pending
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]             level_q, level_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;
  logic [WIDTH-1:0]             busy_q, busy_d;
  logic [WIDTH-1:0]             sync_w;

  assign sync_w = sync_q[STAGES-1];

  // Plain shift chain: din only ever reaches stage 0.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  // Any sample that agrees with level restarts the count, so glitches never accumulate.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (sync_w[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
  logic [WIDTH-1:0] req_q, req_d;

  // Set dominates clear so a request arriving as the controller acknowledges is kept.
  always_comb begin
    req_d = (req_q & ~req_clr) | rise_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_pending = req_q;
`endif

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed self-checking bench for sync_debounce_bank with default parameters.
// Request-latch scenario compiled only when SYNC_DEBOUNCE_REQ_LATCH_EN is defined.
module tb_sync_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'hF;
  logic [3:0] level, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
  logic [3:0] req_clr = 4'h0;
  logic [3:0] req_pending;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  sync_debounce_bank #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
    ,
    .req_clr     (req_clr),
    .req_pending (req_pending)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din   = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #23;
    total_cnt++;
    if (level !== 4'h0) $display("FAIL reset_level got=%h exp=0", level); else pass_cnt++;
    total_cnt++;
    if (rise !== 4'h0) $display("FAIL reset_rise got=%h exp=0", rise); else pass_cnt++;
    total_cnt++;
    if (fall !== 4'h0) $display("FAIL reset_fall got=%h exp=0", fall); else pass_cnt++;
    total_cnt++;
    if (busy !== 4'h0) $display("FAIL reset_busy got=%h exp=0", busy); else pass_cnt++;
`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
    total_cnt++;
    if (req_pending !== 4'h0) $display("FAIL reset_req got=%h exp=0", req_pending); else pass_cnt++;
`endif
    @(posedge clk);
    #1;
    din   = 4'h0;
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total_cnt++;
      if ({level, rise, fall, busy} !== 16'h0)
        $display("FAIL idle_outputs tick=%0d got=%h exp=0", k, {level, rise, fall, busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_step();
    int rise_at = 0, rise_n = 0, fall_at = 0, fall_n = 0, busy_n = 0;
    logic lvl9 = 1'b0, lvl10 = 1'b0;
    din[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (rise[0]) begin rise_n++; rise_at = k; end
      if (fall[0]) fall_n++;
      if (busy[0]) busy_n++;
      if (k == 9)  lvl9 = level[0];
      if (k == 10) lvl10 = level[0];
    end
    total_cnt++;
    if (lvl9 !== 1'b0) $display("FAIL step_level_early got=%b exp=0", lvl9); else pass_cnt++;
    total_cnt++;
    if (lvl10 !== 1'b1) $display("FAIL step_level_at10 got=%b exp=1", lvl10); else pass_cnt++;
    total_cnt++;
    if (rise_at !== 10) $display("FAIL step_rise_time got=%0d exp=10", rise_at); else pass_cnt++;
    total_cnt++;
    if (rise_n !== 1) $display("FAIL step_rise_count got=%0d exp=1", rise_n); else pass_cnt++;
    total_cnt++;
    if (busy_n !== 7) $display("FAIL step_busy_cycles got=%0d exp=7", busy_n); else pass_cnt++;
    total_cnt++;
    if (fall_n !== 0) $display("FAIL step_no_fall got=%0d exp=0", fall_n); else pass_cnt++;
    din[0] = 1'b0;
    rise_n = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (fall[0]) begin fall_n++; fall_at = k; end
      if (rise[0]) rise_n++;
      if (fall[0] && rise[0]) $display("FAIL step_both_pulses tick=%0d got=11 exp=not both", k);
    end
    total_cnt++;
    if (fall_at !== 10) $display("FAIL step_fall_time got=%0d exp=10", fall_at); else pass_cnt++;
    total_cnt++;
    if (fall_n !== 1 || rise_n !== 0)
      $display("FAIL step_fall_count got=fall%0d/rise%0d exp=fall1/rise0", fall_n, rise_n);
    else pass_cnt++;
    total_cnt++;
    if (level[0] !== 1'b0) $display("FAIL step_level_low got=%b exp=0", level[0]); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int rise_n = 0, fall_n = 0, rise_at = 0;
    din[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 8) din[1] = 1'b0;
      tick();
      if (rise[1]) rise_n++;
      if (fall[1]) fall_n++;
    end
    total_cnt++;
    if (rise_n !== 0 || fall_n !== 0 || level[1] !== 1'b0)
      $display("FAIL glitch7_rejected got=rise%0d/fall%0d/lvl%b exp=rise0/fall0/lvl0", rise_n, fall_n, level[1]);
    else pass_cnt++;
    din[1] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 9) din[1] = 1'b0;
      tick();
      if (rise[1]) begin rise_n++; rise_at = k; end
      if (fall[1]) fall_n++;
    end
    total_cnt++;
    if (rise_at !== 10 || rise_n !== 1)
      $display("FAIL glitch8_accepted got=at%0d/n%0d exp=at10/n1", rise_at, rise_n);
    else pass_cnt++;
    total_cnt++;
    if (fall_n !== 1 || level[1] !== 1'b0)
      $display("FAIL glitch8_release got=fall%0d/lvl%b exp=fall1/lvl0", fall_n, level[1]);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int rise_n = 0, fall_n = 0, rise_at = 0;
    for (int j = 0; j < 10; j++) begin
      din[2] = ~din[2];
      for (int k = 0; k < 3; k++) begin
        tick();
        if (rise[2]) rise_n++;
        if (fall[2]) fall_n++;
      end
    end
    din[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (rise[2]) begin rise_n++; rise_at = k; end
      if (fall[2]) fall_n++;
    end
    total_cnt++;
    if (rise_n !== 1 || rise_at !== 10)
      $display("FAIL bounce_single_rise got=n%0d/at%0d exp=n1/at10", rise_n, rise_at);
    else pass_cnt++;
    total_cnt++;
    if (fall_n !== 0) $display("FAIL bounce_no_fall got=%0d exp=0", fall_n); else pass_cnt++;
    total_cnt++;
    if (level[2] !== 1'b1) $display("FAIL bounce_level got=%b exp=1", level[2]); else pass_cnt++;
  endtask

  task automatic test_simultaneous_and_async_reset();
    int fall_n = 0;
    do_reset();
    din = 4'hF;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        total_cnt++;
        if (rise !== 4'h0) $display("FAIL simul_rise_early got=%h exp=0", rise); else pass_cnt++;
      end
      if (k == 10) begin
        total_cnt++;
        if (rise !== 4'hF) $display("FAIL simul_rise got=%h exp=f", rise); else pass_cnt++;
        total_cnt++;
        if (level !== 4'hF) $display("FAIL simul_level got=%h exp=f", level); else pass_cnt++;
      end
    end
    total_cnt++;
    if (rise !== 4'h0) $display("FAIL simul_rise_one_cycle got=%h exp=0", rise); else pass_cnt++;
    din = 4'h0;
    for (int k = 0; k < 5; k++) tick();
    total_cnt++;
    if (busy !== 4'hF) $display("FAIL midcount_busy got=%h exp=f", busy); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({level, rise, fall, busy} !== 16'h0)
      $display("FAIL async_reset got=%h exp=0", {level, rise, fall, busy});
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (fall != 4'h0 || rise != 4'h0) fall_n++;
    end
    total_cnt++;
    if (fall_n !== 0 || level !== 4'h0)
      $display("FAIL reset_drops_pending got=pulses%0d/lvl%h exp=pulses0/lvl0", fall_n, level);
    else pass_cnt++;
  endtask

`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
  task automatic test_req_latch();
    din[3] = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    total_cnt++;
    if (req_pending[3] !== 1'b1) $display("FAIL req_set got=%b exp=1", req_pending[3]); else pass_cnt++;
    din[3] = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    total_cnt++;
    if (req_pending[3] !== 1'b1 || level[3] !== 1'b0)
      $display("FAIL req_hold got=req%b/lvl%b exp=req1/lvl0", req_pending[3], level[3]);
    else pass_cnt++;
    din[3] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total_cnt++;
    if (rise[3] !== 1'b1) $display("FAIL req_rise2 got=%b exp=1", rise[3]); else pass_cnt++;
    req_clr[3] = 1'b1;
    tick();
    total_cnt++;
    if (req_pending[3] !== 1'b1) $display("FAIL req_set_wins got=%b exp=1", req_pending[3]); else pass_cnt++;
    tick();
    total_cnt++;
    if (req_pending[3] !== 1'b0) $display("FAIL req_clear got=%b exp=0", req_pending[3]); else pass_cnt++;
    req_clr[3] = 1'b0;
    tick();
    total_cnt++;
    if (req_pending !== 4'h0) $display("FAIL req_stay_clear got=%h exp=0", req_pending); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous_and_async_reset();
`ifdef SYNC_DEBOUNCE_REQ_LATCH_EN
    test_req_latch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
